// File: rtl/usr_seq_shift.sv
// rtl/usr_seq_shift.sv - parametrised sequential universal shift register, one shift step per cycle; optional q_par output under USR_PARITY_EN
module usr_seq_shift #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
`ifdef USR_PARITY_EN
    output logic             q_par,
`endif
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    state_t           state, state_n;
    logic [AMT_W-1:0] count, count_n;
    logic [2:0]       op_r, op_n;
    logic [WIDTH-1:0] q_n;
    logic             sout_n;
    logic             done_n;

    assign busy = (state == RUN);

    // State register; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath: accept commands in IDLE, perform one step per cycle in RUN
    always_comb begin
        state_n = state;
        count_n = count;
        op_n    = op_r;
        q_n     = q;
        sout_n  = sout;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_NOP: begin
                            done_n = 1'b1;
                        end
                        OP_LOAD: begin
                            q_n    = din;
                            done_n = 1'b1;
                        end
                        OP_CLR: begin
                            q_n    = '0;
                            done_n = 1'b1;
                        end
                        default: begin
                            // zero-length shift completes immediately without entering RUN
                            if (amt == '0) begin
                                done_n = 1'b1;
                            end else begin
                                op_n    = op;
                                count_n = amt;
                                state_n = RUN;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                case (op_r)
                    OP_SHL: begin
                        q_n    = {q[WIDTH-2:0], sin};
                        sout_n = q[WIDTH-1];
                    end
                    OP_SHR: begin
                        q_n    = {sin, q[WIDTH-1:1]};
                        sout_n = q[0];
                    end
                    OP_ROL: begin
                        q_n    = {q[WIDTH-2:0], q[WIDTH-1]};
                        sout_n = q[WIDTH-1];
                    end
                    OP_ROR: begin
                        q_n    = {q[0], q[WIDTH-1:1]};
                        sout_n = q[0];
                    end
                    OP_ASR: begin
                        q_n    = {q[WIDTH-1], q[WIDTH-1:1]};
                        sout_n = q[0];
                    end
                    default: begin
                        q_n    = q;
                        sout_n = sout;
                    end
                endcase
                count_n = count - 1'b1;
                if (count == AMT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            q     <= '0;
            sout  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            op_r  <= OP_NOP;
        end else begin
            q     <= q_n;
            sout  <= sout_n;
            done  <= done_n;
            count <= count_n;
            op_r  <= op_n;
        end
    end

`ifdef USR_PARITY_EN
    // Parity tracks the value q takes at the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_par <= 1'b0;
        end else begin
            q_par <= ^q_n;
        end
    end
`endif

endmodule
